// File: rtl/mem_responder.sv
// Word-addressed memory responder with a four-phase req/ack handshake and WAIT_CYCLES wait states.
// Optional macro MEM_RESP_BOUNDS_CHECK_EN flags out-of-range addresses via err instead of wrapping.
module mem_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_l_q, we_l_d;
  logic [ADDR_WIDTH-1:0] addr_l_q, addr_l_d;
  logic [DATA_WIDTH-1:0] wdata_l_q, wdata_l_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_we_d;
  logic [IDX_W-1:0]      idx_s;
  logic                  oob_s;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Out-of-range addresses wrap modulo the implemented depth.
  assign idx_s = IDX_W'(32'(addr_l_q) % 32'(MEM_DEPTH));

`ifdef MEM_RESP_BOUNDS_CHECK_EN
  assign oob_s = (32'(addr_l_q) >= 32'(MEM_DEPTH));
`else
  assign oob_s = 1'b0;
`endif

  // Handshake sequencing; the counter runs down to zero so ack lands WAIT_CYCLES+1 edges after acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_l_d    = we_l_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mem_we_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_l_d    = we;
          addr_l_d  = addr;
          wdata_l_d = wdata;
          cnt_d     = 4'(WAIT_CYCLES);
          state_d   = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          err_d   = oob_s;
          if (we_l_q) begin
            mem_we_d = !oob_s;
          end else begin
            rdata_d = oob_s ? {DATA_WIDTH{1'b0}} : mem_q[idx_s];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (!req) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = ACK;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_l_q    <= 1'b0;
      addr_l_q  <= {ADDR_WIDTH{1'b0}};
      wdata_l_q <= {DATA_WIDTH{1'b0}};
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_l_q    <= we_l_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage survives reset, but a write due on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_d && !reset) begin
      mem_q[idx_s] <= wdata_l_q;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 wait states / depth 256, and 0 wait states / depth 16)
// checked every cycle against a latency-based transaction model plus hand-computed literals.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0]      req_v, we_v;
  logic [1:0][7:0] addr_p, wdata_p;
  wire  [1:0]      ack_w, busy_w, err_w;
  wire  [1:0][7:0] rdata_w;

  int n_vec = 0;
  int n_err = 0;

  mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_p[0]), .wdata(wdata_p[0]),
    .ack(ack_w[0]), .rdata(rdata_w[0]), .busy(busy_w[0]), .err(err_w[0]));

  mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(16), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_p[1]), .wdata(wdata_p[1]),
    .ack(ack_w[1]), .rdata(rdata_w[1]), .busy(busy_w[1]), .err(err_w[1]));

  // Model: a request is accepted in idle, completes (WAIT_CYCLES+1) edges later unless req drops first.
  int       wc  [2] = '{2, 0};
  int       dep [2] = '{256, 16};
`ifdef MEM_RESP_BOUNDS_CHECK_EN
  bit       bc = 1'b1;
`else
  bit       bc = 1'b0;
`endif
  logic [7:0] mm [2][256];
  bit         m_pend [2];
  bit         m_ack  [2];
  bit         m_err  [2];
  int         m_age  [2];
  logic       m_we   [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wd   [2];
  logic [7:0] m_rd   [2];

  task automatic model_step(input int d);
    int idx;
    bit oob;
    if (reset) begin
      m_pend[d] = 1'b0; m_ack[d] = 1'b0; m_err[d] = 1'b0; m_rd[d] = 8'h00;
    end else if (m_ack[d]) begin
      if (!req_v[d]) begin
        m_ack[d] = 1'b0; m_err[d] = 1'b0;
      end
    end else if (m_pend[d]) begin
      if (!req_v[d]) begin
        m_pend[d] = 1'b0;
      end else begin
        m_age[d] = m_age[d] + 1;
        if (m_age[d] == wc[d] + 1) begin
          idx = int'(m_addr[d]) % dep[d];
          oob = bc && (int'(m_addr[d]) >= dep[d]);
          if (m_we[d]) begin
            if (!oob) mm[d][idx] = m_wd[d];
          end else begin
            m_rd[d] = oob ? 8'h00 : mm[d][idx];
          end
          m_err[d]  = oob;
          m_ack[d]  = 1'b1;
          m_pend[d] = 1'b0;
        end
      end
    end else if (req_v[d]) begin
      m_pend[d] = 1'b1; m_age[d] = 0;
      m_we[d] = we_v[d]; m_addr[d] = addr_p[d]; m_wd[d] = wdata_p[d];
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 1'b0; m_ack[d] = 1'b0; m_err[d] = 1'b0; m_rd[d] = 8'h00; m_age[d] = 0;
    end
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (ack_w[d] !== m_ack[d] || busy_w[d] !== (m_pend[d] | m_ack[d]) ||
            rdata_w[d] !== m_rd[d] || err_w[d] !== m_err[d]) begin
          n_err++;
          $display("FAIL model_cmp dut%0d t=%0t: ack/busy/rdata/err got %b/%b/%h/%b expected %b/%b/%h/%b",
                   d, $time, ack_w[d], busy_w[d], rdata_w[d], err_w[d],
                   m_ack[d], m_pend[d] | m_ack[d], m_rd[d], m_err[d]);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd);
    req_v[d] = 1'b1; we_v[d] = w; addr_p[d] = a; wdata_p[d] = wd;
  endtask

  task automatic wait_ack(input int d, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack_w[d] === 1'b1) begin
        lat = c - 1;
        break;
      end
    end
    if (lat < 0) lit("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_req(input int d, input int hold);
    for (int h = 0; h < hold; h++) begin
      addr_p[d] = ~addr_p[d]; wdata_p[d] = wdata_p[d] + 8'd37; we_v[d] = ~we_v[d];
      @(negedge clk);
      lit("ack_held", 32'(ack_w[d]), 32'd1);
    end
    req_v[d] = 1'b0;
    @(negedge clk);
    lit("ack_fall", 32'(ack_w[d]), 32'd0);
  endtask

  task automatic xact(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                      input int hold, output logic [7:0] rd, output logic er);
    int lat;
    issue(d, w, a, wd);
    wait_ack(d, lat);
    lit("ack_latency", 32'(lat), 32'(wc[d] + 1));
    rd = rdata_w[d];
    er = err_w[d];
    release_req(d, hold);
    if (hold > 0) lit("rdata_stable", 32'(rdata_w[d]), 32'(rd));
  endtask

  logic [7:0] rd;
  logic       er;
  int         lat;

  initial begin
    reset = 1'b1; req_v = 2'b00; we_v = 2'b00; addr_p = '0; wdata_p = '0;
    repeat (3) @(negedge clk);
    lit("reset_ack", 32'(ack_w), 32'd0);
    lit("reset_busy", 32'(busy_w), 32'd0);
    lit("reset_rdata0", 32'(rdata_w[0]), 32'd0);
    lit("reset_err", 32'(err_w), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write then read, two wait states.
    xact(0, 1'b1, 8'h10, 8'h5A, 0, rd, er);
    xact(0, 1'b0, 8'h10, 8'h00, 0, rd, er);
    lit("rd_0x10", 32'(rd), 32'h5A);
    // Hold ack five extra cycles while toggling inputs.
    xact(0, 1'b0, 8'h10, 8'h00, 5, rd, er);
    lit("rd_0x10_hold", 32'(rd), 32'h5A);

    // Abort a write in WAIT.
    xact(0, 1'b1, 8'h07, 8'h11, 0, rd, er);
    issue(0, 1'b1, 8'h07, 8'hFF);
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      lit("abort_noack", 32'(ack_w[0]), 32'd0);
    end
    xact(0, 1'b0, 8'h07, 8'h00, 0, rd, er);
    lit("abort_rd7", 32'(rd), 32'h11);

    // Reset while a write sits in WAIT.
    xact(0, 1'b1, 8'h04, 8'h44, 0, rd, er);
    issue(0, 1'b1, 8'h04, 8'h33);
    @(negedge clk);
    reset = 1'b1; req_v[0] = 1'b0;
    @(negedge clk);
    lit("rstwait_ack", 32'(ack_w[0]), 32'd0);
    lit("rstwait_busy", 32'(busy_w[0]), 32'd0);
    lit("rstwait_rdata", 32'(rdata_w[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    xact(0, 1'b0, 8'h04, 8'h00, 0, rd, er);
    lit("rstwait_rd4", 32'(rd), 32'h44);

    // Reset while ack is held.
    issue(0, 1'b0, 8'h10, 8'h00);
    wait_ack(0, lat);
    reset = 1'b1;
    @(negedge clk);
    lit("rstack_ack", 32'(ack_w[0]), 32'd0);
    lit("rstack_busy", 32'(busy_w[0]), 32'd0);
    lit("rstack_rdata", 32'(rdata_w[0]), 32'd0);
    req_v[0] = 1'b0; reset = 1'b0;
    @(negedge clk);
    xact(0, 1'b0, 8'h10, 8'h00, 0, rd, er);
    lit("retained_0x10", 32'(rd), 32'h5A);

    // Zero wait states: back-to-back writes then a read.
    xact(1, 1'b1, 8'h03, 8'h01, 0, rd, er);
    xact(1, 1'b1, 8'h03, 8'h02, 0, rd, er);
    xact(1, 1'b0, 8'h03, 8'h00, 0, rd, er);
    lit("raw_rd3", 32'(rd), 32'h02);

    // Depth-16 instance: address 0x14 against address 0x04.
    xact(1, 1'b1, 8'h04, 8'h5C, 0, rd, er);
    xact(1, 1'b1, 8'h14, 8'hA5, 0, rd, er);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    lit("oob_wr_err", 32'(er), 32'd1);
    xact(1, 1'b0, 8'h04, 8'h00, 0, rd, er);
    lit("oob_rd4", 32'(rd), 32'h5C);
    lit("oob_rd4_err", 32'(er), 32'd0);
    xact(1, 1'b0, 8'h14, 8'h00, 0, rd, er);
    lit("oob_rd14", 32'(rd), 32'h00);
    lit("oob_rd14_err", 32'(er), 32'd1);
    lit("oob_err_clear", 32'(err_w[1]), 32'd0);
`else
    lit("wrap_wr_err", 32'(er), 32'd0);
    xact(1, 1'b0, 8'h04, 8'h00, 0, rd, er);
    lit("wrap_rd4", 32'(rd), 32'hA5);
    lit("wrap_rd4_err", 32'(er), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
